mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - CPU load/store unit: big-endian lanes, byte/half read-modify-write, registered strobes
module mem_access_unit #(
  parameter int unsigned MEM_TOP = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] Daddr,
  output logic [31:0] DataIn,
  input  logic [31:0] DataOut,
  output logic        mRD,
  output logic        mWR
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q;
  logic        we_q, signed_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rbuf_q, rsp_rdata_q;
  logic        mrd_q, mwr_q, rsp_valid_q, rsp_err_q;
  logic        req_err_d;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      2'b00:   load_ext = sgn ? {{24{b[7]}}, b} : {24'b0, b};
      2'b01:   load_ext = sgn ? {{16{h[15]}}, h} : {16'b0, h};
      default: load_ext = w;
    endcase
  endfunction

  // Word stores pass wdata straight through; narrower stores patch one lane of the read buffer.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] sz,
                                        input logic [1:0] off, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) begin
      case (off)
        2'd0:    r[31:24] = d[7:0];
        2'd1:    r[23:16] = d[7:0];
        2'd2:    r[15:8]  = d[7:0];
        default: r[7:0]   = d[7:0];
      endcase
    end else if (sz == 2'b01) begin
      if (off[1]) r[15:0] = d[15:0];
      else        r[31:16] = d[15:0];
    end else begin
      r = d;
    end
    merge = r;
  endfunction

  always_comb begin
    req_err_d = 1'b0;
    case (req_size)
      2'b11:   req_err_d = 1'b1;
      2'b01:   req_err_d = req_addr[0];
      2'b10:   req_err_d = (req_addr[1:0] != 2'b00);
      default: req_err_d = 1'b0;
    endcase
    if (({1'b0, req_addr[31:2], 2'b00} + 33'd3) > 33'(MEM_TOP)) req_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rbuf_q      <= 32'd0;
      rsp_rdata_q <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      mrd_q       <= 1'b1;
      mwr_q       <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q     <= req_we;
          signed_q <= req_signed;
          size_q   <= req_size;
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          if (req_err_d) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 32'd0;
          end else if (req_we && req_size == 2'b10) begin
            state_q <= WRITE;
            mwr_q   <= 1'b0;
          end else begin
            state_q <= READ;
            mrd_q   <= 1'b0;
          end
        end
        READ: begin
          mrd_q  <= 1'b1;
          rbuf_q <= DataOut;
          if (we_q) begin
            state_q <= WRITE;
            mwr_q   <= 1'b0;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= load_ext(DataOut, size_q, addr_q[1:0], signed_q);
          end
        end
        WRITE: begin
          mwr_q       <= 1'b1;
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= 32'd0;
        end
        RESP: if (rsp_ready) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= 32'd0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Address and write word derive only from latched request state, so they hold through READ/WRITE.
  assign Daddr     = {addr_q[31:2], 2'b00};
  assign DataIn    = merge(rbuf_q, size_q, addr_q[1:0], wdata_q);
  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mRD       = mrd_q;
  assign mWR       = mwr_q;

endmodule
